// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: default widths,
// FSM state encoding and a saturating counter helper.
package instruction_fetch_controller_pkg;

  // Default instruction-memory word-address width and instruction width.
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Width of the accepted-instruction counter.
  localparam int FETCH_COUNT_WIDTH = 16;

  // Fetch FSM encoding. 2'd3 is unused and decodes back to FETCH.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FETCH_COUNT_WIDTH-1:0] sat_inc(
    input logic [FETCH_COUNT_WIDTH-1:0] value
  );
    if (value == {FETCH_COUNT_WIDTH{1'b1}}) begin
      return value;
    end
    return value + FETCH_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/program_counter_unit.sv
// Next-PC arithmetic: sequential increment, plus a word offset when a taken
// branch is signalled. Only the low ADDR_WIDTH bits of the offset matter
// because the PC wraps modulo 2^ADDR_WIDTH.
module program_counter_unit
  import instruction_fetch_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] program_counter,
  input  logic [DATA_WIDTH-1:0] shifted_immediate_extended,
  input  logic                  branch,
  output logic [ADDR_WIDTH-1:0] new_program_counter
);

  logic [ADDR_WIDTH-1:0] offset;
  logic                  unused_imm_hi;

  // Offset is the truncated immediate on a taken branch, zero otherwise.
  always_comb begin
    offset              = branch ? shifted_immediate_extended[ADDR_WIDTH-1:0] : '0;
    new_program_counter = program_counter + ADDR_WIDTH'(1) + offset;
  end

  // Upper immediate bits cannot affect a wrapped PC; fold them away.
  assign unused_imm_hi = ^shifted_immediate_extended[DATA_WIDTH-1:ADDR_WIDTH];

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: issues one read at a time to instruction
// memory, holds the returned word for decode until it is accepted, then
// advances the PC (sequentially or by a branch offset) and counts accepts.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         imem_read,
  output logic [ADDR_WIDTH-1:0]        imem_address,
  input  logic                         imem_ready,
  input  logic [DATA_WIDTH-1:0]        imem_instruction,
  output logic [DATA_WIDTH-1:0]        instruction,
  output logic                         instruction_valid,
  input  logic                         decode_ready,
  output logic [ADDR_WIDTH-1:0]        program_counter,
  input  logic                         branch,
  input  logic [DATA_WIDTH-1:0]        shifted_immediate_extended,
  output logic [FETCH_COUNT_WIDTH-1:0] fetch_count
);

  fetch_state_e                   state_q;
  logic [ADDR_WIDTH-1:0]          pc_q;
  logic [ADDR_WIDTH-1:0]          pc_d;
  logic [DATA_WIDTH-1:0]          instruction_q;
  logic [FETCH_COUNT_WIDTH-1:0]   fetch_count_q;
  logic [FETCH_COUNT_WIDTH-1:0]   fetch_count_d;
  logic                           in_fetch;
  logic                           in_wait;
  logic                           in_valid;
  logic                           accept;

  // State decodes shared by the FSM and the output logic.
  assign in_fetch = (state_q == FETCH);
  assign in_wait  = (state_q == WAIT);
  assign in_valid = (state_q == VALID);

  // Decode takes the presented instruction this cycle.
  assign accept = in_valid & decode_ready;

  // Next PC is always computed, but only committed on acceptance, so branch
  // and the immediate have no effect in any other cycle.
  program_counter_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_program_counter_unit (
    .program_counter            (pc_q),
    .shifted_immediate_extended (shifted_immediate_extended),
    .branch                     (branch),
    .new_program_counter        (pc_d)
  );

  assign fetch_count_d = sat_inc(fetch_count_q);

  // Fetch FSM with PC, held instruction and accept counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= '0;
      instruction_q <= '0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          // The read strobe is issued in this cycle when enabled.
          if (enable) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Wait indefinitely; memory guarantees an eventual response.
          if (imem_ready) begin
            instruction_q <= imem_instruction;
            state_q       <= VALID;
          end
        end
        VALID: begin
          // Hold instruction and PC until decode takes them.
          if (decode_ready) begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            state_q       <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // The strobe is qualified by reset so nothing is requested while the
  // memory (which shares reset) is being cleared.
  assign imem_read         = in_fetch & enable & ~reset;
  assign imem_address      = pc_q;
  assign instruction       = instruction_q;
  assign instruction_valid = in_valid;
  assign program_counter   = pc_q;
  assign fetch_count       = fetch_count_q;

  // WAIT contributes no output of its own beyond suppressing the strobe.
  logic unused_in_wait;
  assign unused_in_wait = in_wait & accept;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Scoreboard bench for the instruction fetch controller: every read gets a
// random response word whose expected {address, data} is queued when driven
// and compared when decode sees the instruction.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        imem_read;
  logic [5:0]  imem_address;
  logic        imem_ready;
  logic [31:0] imem_instruction;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        decode_ready;
  logic [5:0]  program_counter;
  logic        branch;
  logic [31:0] shifted_immediate_extended;
  logic [15:0] fetch_count;

  instruction_fetch_controller dut (
    .clk                        (clk),
    .reset                      (reset),
    .enable                     (enable),
    .imem_read                  (imem_read),
    .imem_address               (imem_address),
    .imem_ready                 (imem_ready),
    .imem_instruction           (imem_instruction),
    .instruction                (instruction),
    .instruction_valid          (instruction_valid),
    .decode_ready               (decode_ready),
    .program_counter            (program_counter),
    .branch                     (branch),
    .shifted_immediate_extended (shifted_immediate_extended),
    .fetch_count                (fetch_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  logic [5:0]  model_pc = 6'd0;
  int          model_count = 0;
  logic [31:0] last_instr = 32'd0;

  logic [5:0]  o_addr;
  logic [31:0] o_instr;
  logic [5:0]  o_pc;
  int          o_rc;
  bit          o_to;
  int          o_extra;
  int          o_early;
  int          o_hold_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch transaction: wait for the read, answer after mem_lat WAIT
  // cycles, keep decode stalled for hold VALID cycles (with noise on the
  // ignored inputs), then accept with the given branch/offset.
  task automatic fetch_one(input logic br, input logic [31:0] off, input int mem_lat,
                           input logic [31:0] data, input int hold,
                           output logic [5:0] a, output logic [31:0] ins, output logic [5:0] pc,
                           output int rc, output bit to, output int extra, output int early,
                           output int hold_bad);
    int n;
    a = '0; ins = '0; pc = '0; rc = 0; to = 0; extra = 0; early = 0; hold_bad = 0;
    enable = 1'b1;
    #1;
    n = 0;
    while (!imem_read && n < 20) begin
      if (instruction_valid) early++;
      tick();
      #1;
      n++;
    end
    if (!imem_read) begin
      to = 1;
      return;
    end
    a  = imem_address;
    rc = cyc;
    if (instruction_valid) early++;
    tick();
    for (int k = 0; k < mem_lat; k++) begin
      imem_ready = 1'b0;
      imem_instruction = $urandom;
      #1;
      if (imem_read) extra++;
      if (instruction_valid) early++;
      tick();
    end
    imem_ready = 1'b1;
    imem_instruction = data;
    #1;
    if (imem_read) extra++;
    if (instruction_valid) early++;
    tick();
    imem_ready = 1'b0;
    decode_ready = 1'b0;
    #1;
    n = 0;
    while (!instruction_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (!instruction_valid) begin
      to = 1;
      return;
    end
    ins = instruction;
    pc  = program_counter;
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) tick();
      if (k == hold) begin
        decode_ready = 1'b1;
        branch = br;
        shifted_immediate_extended = off;
      end else begin
        decode_ready = 1'b0;
        branch = 1'($urandom_range(0, 1));
        shifted_immediate_extended = $urandom;
      end
      imem_instruction = $urandom;
      imem_ready = 1'($urandom_range(0, 1));
      #1;
      if (!instruction_valid || instruction !== ins || program_counter !== pc) hold_bad++;
      if (imem_read) extra++;
    end
    tick();
    decode_ready = 1'b0;
    branch = 1'b0;
    shifted_immediate_extended = $urandom;
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; imem_ready = 1'b0; imem_instruction = 32'hDEAD_BEEF;
    decode_ready = 1'b1; branch = 1'b1; shifted_immediate_extended = 32'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      checks++;
      if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_read[%0d] got %b expected 0", k, imem_read); end
      checks++;
      if (instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b expected 0", k, instruction_valid); end
    end
    checks++;
    if (program_counter !== 6'd0) begin errors++; $display("FAIL reset_pc got %0d expected 0", program_counter); end
    checks++;
    if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", fetch_count); end
    checks++;
    if (instruction !== 32'd0) begin errors++; $display("FAIL reset_instr got %h expected 0", instruction); end
    reset = 1'b0; enable = 1'b0; decode_ready = 1'b0; branch = 1'b0;
    tick();
    #1;
    checks++;
    if (imem_read !== 1'b0) begin errors++; $display("FAIL idle_read got %b expected 0", imem_read); end
    $display("reset: pc=%0d count=%0d", program_counter, fetch_count);
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      e.addr = model_pc; e.data = d; sb_q.push_back(e);
      fetch_one(1'b0, 32'd0, 1, d, 0, o_addr, o_instr, o_pc, o_rc, o_to, o_extra, o_early, o_hold_bad);
      model_pc = model_pc + 6'd1; model_count++;
      e = sb_q.pop_front(); last_instr = e.data;
      $display("seq: addr=%0d instr=%h pc=%0d", o_addr, o_instr, o_pc);
      checks++;
      if (o_to) begin errors++; $display("FAIL seq_timeout[%0d] got timeout expected response", i); end
      checks++;
      if (o_addr !== e.addr) begin errors++; $display("FAIL seq_addr[%0d] got %0d expected %0d", i, o_addr, e.addr); end
      checks++;
      if (o_addr !== 6'(i)) begin errors++; $display("FAIL seq_spec_addr[%0d] got %0d expected %0d", i, o_addr, i); end
      checks++;
      if (o_instr !== e.data) begin errors++; $display("FAIL seq_instr[%0d] got %h expected %h", i, o_instr, e.data); end
      checks++;
      if (o_pc !== e.addr) begin errors++; $display("FAIL seq_pc[%0d] got %0d expected %0d", i, o_pc, e.addr); end
      checks++;
      if (o_extra != 0 || o_early != 0) begin errors++; $display("FAIL seq_strobes[%0d] got extra=%0d early=%0d expected 0/0", i, o_extra, o_early); end
    end
    checks++;
    if (fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count got %0d expected 4", fetch_count); end
  endtask

  // Branch table walks pc 4 -> 12 -> 7 -> 7 -> 8 -> 9 -> 63 -> 0 -> 1 -> 2.
  task automatic test_branch_and_wrap();
    logic        br_t   [10];
    logic [31:0] off_t  [10];
    logic [5:0]  addr_t [10];
    logic [31:0] d;
    br_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    off_t = '{32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000,
              32'h0000_0035, 32'h0000_0011, 32'h1234_5640, 32'h0000_0000, 32'h0000_0000};
    addr_t = '{6'd4, 6'd12, 6'd7, 6'd7, 6'd8, 6'd9, 6'd63, 6'd0, 6'd1, 6'd2};
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      e.addr = model_pc; e.data = d; sb_q.push_back(e);
      fetch_one(br_t[i], off_t[i], i % 3, d, 0, o_addr, o_instr, o_pc, o_rc, o_to, o_extra, o_early, o_hold_bad);
      model_pc = model_pc + 6'd1 + (br_t[i] ? off_t[i][5:0] : 6'd0); model_count++;
      e = sb_q.pop_front(); last_instr = e.data;
      $display("branch: addr=%0d instr=%h br=%b off=%h", o_addr, o_instr, br_t[i], off_t[i]);
      checks++;
      if (o_to) begin errors++; $display("FAIL br_timeout[%0d] got timeout expected response", i); end
      checks++;
      if (o_addr !== e.addr) begin errors++; $display("FAIL br_addr[%0d] got %0d expected %0d", i, o_addr, e.addr); end
      checks++;
      if (o_addr !== addr_t[i]) begin errors++; $display("FAIL br_spec_addr[%0d] got %0d expected %0d", i, o_addr, addr_t[i]); end
      checks++;
      if (o_instr !== e.data || o_pc !== e.addr) begin errors++; $display("FAIL br_data[%0d] got %h/%0d expected %h/%0d", i, o_instr, o_pc, e.data, e.addr); end
    end
    checks++;
    if (fetch_count !== 16'(model_count)) begin errors++; $display("FAIL br_count got %0d expected %0d", fetch_count, model_count); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      e.addr = model_pc; e.data = d; sb_q.push_back(e);
      fetch_one(1'b0, 32'h0000_0009, 3, d, (i == 0) ? 5 : 0, o_addr, o_instr, o_pc, o_rc, o_to, o_extra, o_early, o_hold_bad);
      model_pc = model_pc + 6'd1; model_count++;
      e = sb_q.pop_front(); last_instr = e.data;
      $display("stall: addr=%0d instr=%h hold_bad=%0d", o_addr, o_instr, o_hold_bad);
      checks++;
      if (o_to) begin errors++; $display("FAIL stall_timeout[%0d] got timeout expected response", i); end
      checks++;
      if (o_addr !== e.addr) begin errors++; $display("FAIL stall_addr[%0d] got %0d expected %0d", i, o_addr, e.addr); end
      checks++;
      if (o_instr !== e.data || o_pc !== e.addr) begin errors++; $display("FAIL stall_data[%0d] got %h/%0d expected %h/%0d", i, o_instr, o_pc, e.data, e.addr); end
      checks++;
      if (o_hold_bad != 0 || o_extra != 0) begin errors++; $display("FAIL stall_hold[%0d] got changes=%0d reads=%0d expected 0/0", i, o_hold_bad, o_extra); end
    end
    checks++;
    if (fetch_count !== 16'(model_count)) begin errors++; $display("FAIL stall_count got %0d expected %0d", fetch_count, model_count); end
  endtask

  task automatic test_ready_outside_wait();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'b1;
      imem_instruction = $urandom;
      #1;
      checks++;
      if (imem_read !== 1'b0 || instruction_valid !== 1'b0) begin errors++; $display("FAIL stray_ready_state[%0d] got read=%b valid=%b expected 0/0", k, imem_read, instruction_valid); end
      checks++;
      if (instruction !== last_instr || program_counter !== model_pc) begin errors++; $display("FAIL stray_ready_hold[%0d] got %h/%0d expected %h/%0d", k, instruction, program_counter, last_instr, model_pc); end
      $display("stray ready: instr=%h pc=%0d", instruction, program_counter);
      tick();
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int prev_rc;
    prev_rc = 0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      e.addr = model_pc; e.data = d; sb_q.push_back(e);
      fetch_one(1'b0, 32'd0, 0, d, 0, o_addr, o_instr, o_pc, o_rc, o_to, o_extra, o_early, o_hold_bad);
      model_pc = model_pc + 6'd1; model_count++;
      e = sb_q.pop_front(); last_instr = e.data;
      $display("b2b: addr=%0d instr=%h read_cycle=%0d", o_addr, o_instr, o_rc);
      checks++;
      if (o_to || o_addr !== e.addr || o_instr !== e.data) begin errors++; $display("FAIL b2b_txn[%0d] got %0d/%h expected %0d/%h", i, o_addr, o_instr, e.addr, e.data); end
      if (i > 0) begin
        checks++;
        if (o_rc - prev_rc != 3) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d expected 3", i, o_rc - prev_rc); end
      end
      prev_rc = o_rc;
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    enable = 1'b1;
    #1;
    n = 0;
    while (!imem_read && n < 20) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (!imem_read) begin errors++; $display("FAIL rstwait_read got 0 expected 1"); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    $display("reset in wait: valid=%b pc=%0d count=%0d read=%b", instruction_valid, program_counter, fetch_count, imem_read);
    checks++;
    if (instruction_valid !== 1'b0) begin errors++; $display("FAIL rstwait_valid got %b expected 0", instruction_valid); end
    checks++;
    if (program_counter !== 6'd0) begin errors++; $display("FAIL rstwait_pc got %0d expected 0", program_counter); end
    checks++;
    if (fetch_count !== 16'd0) begin errors++; $display("FAIL rstwait_count got %0d expected 0", fetch_count); end
    checks++;
    if (instruction !== 32'd0) begin errors++; $display("FAIL rstwait_instr got %h expected 0", instruction); end
    checks++;
    if (imem_read !== 1'b1 || imem_address !== 6'd0) begin errors++; $display("FAIL rstwait_refetch got read=%b addr=%0d expected 1/0", imem_read, imem_address); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_and_wrap();
    test_stall();
    test_ready_outside_wait();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
